stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive clock cycles a synchronized button level must differ from its debounced level before the debounced level changes.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles each display digit stays selected.
REQ-003 Port clock  input  1  rising-edge system clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port tick  input  1  one-cycle count-rate strobe from the clock divider.
REQ-006 Port btn_ss  input  1  raw start/stop button, active-high, asynchronous.
REQ-007 Port btn_lr  input  1  raw lap/reset button, active-high, asynchronous.
REQ-008 Port count_in  input  16  live BCD count from the counter chain; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-009 Port inc  output  1  increment strobe to counter digit 0.
REQ-010 Port clr  output  1  synchronous clear pulse to all counters.
REQ-011 Port state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-012 Port ovf  output  1  sticky overflow flag.
REQ-013 Port disp_bcd  output  4  BCD digit for the currently selected display position.
REQ-014 Port disp_an  output  4  one-hot, active-high digit select; bit n selects digit n.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer and then a debouncer controlled by DEB_CYCLES; the debounce counter SHALL restart whenever the synchronized level matches the debounced level.
REQ-016 A 0->1 transition of a debounced level SHALL generate a single-cycle press event (ss_press or lr_press); release SHALL generate no event.
REQ-017 From a raw edge, held stable, to its press event the latency SHALL be exactly DEB_CYCLES+2 clock cycles.
REQ-018 IDLE: ss_press -> RUN; lr_press -> remain in IDLE and issue clr.
REQ-019 RUN: ss_press -> PAUSE; lr_press -> LAP and capture count_in into the 16-bit lap register in that same cycle.
REQ-020 LAP: ss_press -> PAUSE; lr_press -> RUN; counting continues while in LAP.
REQ-021 PAUSE: ss_press -> RUN; lr_press -> IDLE and issue clr.
REQ-022 If ss_press and lr_press fall in the same cycle, ss_press SHALL take priority and lr_press SHALL be discarded.
REQ-023 inc SHALL be a registered copy of (tick AND state in {RUN, LAP}), so it is asserted exactly one cycle after the qualifying tick and lasts one cycle.
REQ-024 clr SHALL be a registered single-cycle pulse, asserted the cycle after the causing press.
REQ-025 inc SHALL be forced to 0 in any cycle where clr is 1.
REQ-026 ovf SHALL set when inc is asserted while count_in == 16'h5999 (59:99 wraps to 00:00).
REQ-027 ovf SHALL clear only on clr or reset.
REQ-028 A scan prescaler SHALL advance the digit index 0->1->2->3->0 every SCAN_DIV clock cycles.
REQ-029 disp_an SHALL equal one-hot(index), registered.
REQ-030 disp_bcd SHALL equal the nibble at the current index, taken from the lap register in LAP and from count_in in all other states, registered; it SHALL be aligned in the same cycle as disp_an.
REQ-031 The scan SHALL free-run in every state, including IDLE.

Reset
REQ-032 On reset the block SHALL set state=IDLE, inc=0, clr=0, ovf=0, lap register=0, scan index=0, disp_an=4'b0001, disp_bcd=0, and prescaler, synchronizers, debounced levels and debounce counters to 0.
REQ-033 Reset asserted mid-operation SHALL override every pending press and tick, and SHALL NOT generate clr.
REQ-034 A button already held when reset releases SHALL produce its press event DEB_CYCLES+2 cycles after release.

Verification
REQ-035 Raise btn_ss for 8 cycles from IDLE -> ss_press at cycle 6, state=01 next cycle; tick pulses then yield inc one cycle after each.
REQ-036 Pulse btn_ss for 2 cycles (bounce) -> no press event, state unchanged.
REQ-037 In RUN with count_in=16'h0123, press btn_lr -> state=11, lap=0123; driving count_in=16'h0456 keeps disp_bcd cycling 3,2,1,0; pressing btn_lr again returns state=01 and shows 6,5,4,0.
REQ-038 Press btn_ss while in RUN, then btn_lr -> state 10 then 00, clr=1 for exactly one cycle, inc=0 for the rest of the sequence.
REQ-039 In RUN with count_in=16'h5999, pulse tick -> inc=1 and ovf=1; ovf holds until the next clr.
REQ-040 Assert btn_ss and btn_lr together from RUN -> state=10 only, no lap capture, no clr; assert reset for 1 cycle -> all REQ-032 values.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions the two push buttons, runs the
// IDLE/RUN/PAUSE/LAP control FSM, drives the counter-chain strobes,
// keeps a sticky overflow flag and scans a 4-digit multiplexed display.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int SCAN_DIV   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [15:0] count_in,
  output logic        inc,
  output logic        clr,
  output logic [1:0]  state,
  output logic        ovf,
  output logic [3:0]  disp_bcd,
  output logic [3:0]  disp_an
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // bit 0 is the start/stop button, bit 1 the lap/reset button
  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       ss_press;
  logic       lr_press;

  assign btn_raw  = {btn_lr, btn_ss};
  assign ss_press = press[0];
  assign lr_press = press[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           deb_q;
    logic           deb_d;
    logic           press_q;
    logic           press_d;
    logic [DCW-1:0] cnt_q;
    logic [DCW-1:0] cnt_d;

    // Debounce: count consecutive disagreeing cycles, restart on agreement.
    always_comb begin
      cnt_d   = '0;
      deb_d   = deb_q;
      press_d = 1'b0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DCW'(DEB_CYCLES - 1)) begin
          deb_d   = sync2_q;
          press_d = sync2_q;   // only the rising debounced edge is an event
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Two-flop synchronizer, debounced level and one-cycle press pulse.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign press[gi] = press_q;
  end

  logic [1:0]    state_q, state_d;
  logic [15:0]   lap_q, lap_d;
  logic          inc_q, inc_d;
  logic          clr_q, clr_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [15:0]   disp_src;
  logic          counting;

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);

  // Next state, lap capture and clear request; start/stop beats lap/reset.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    if (ss_press) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_LAP:   state_d = ST_PAUSE;
        default:  state_d = ST_RUN;
      endcase
    end else if (lr_press) begin
      case (state_q)
        ST_IDLE:  clr_d = 1'b1;
        ST_RUN: begin
          state_d = ST_LAP;
          lap_d   = count_in;
        end
        ST_LAP:   state_d = ST_RUN;
        default: begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      endcase
    end
  end

  // Counter strobe (never alongside a clear) and sticky overflow flag.
  always_comb begin
    inc_d = tick && counting && !clr_d;
    ovf_d = ovf_q;
    if (clr_q) begin
      ovf_d = 1'b0;
    end else if (inc_q && (count_in == 16'h5999)) begin
      ovf_d = 1'b1;
    end
  end

  // Free-running digit scan; select and digit both follow the next index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    an_d     = 4'b0001 << idx_d;
    disp_src = (state_q == ST_LAP) ? lap_q : count_in;
    case (idx_d)
      2'd0:    bcd_d = disp_src[3:0];
      2'd1:    bcd_d = disp_src[7:4];
      2'd2:    bcd_d = disp_src[11:8];
      default: bcd_d = disp_src[15:12];
    endcase
  end

  // Control and display registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lap_q   <= '0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b0001;
      bcd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
    end
  end

  assign state    = state_q;
  assign inc      = inc_q;
  assign clr      = clr_q;
  assign ovf      = ovf_q;
  assign disp_an  = an_q;
  assign disp_bcd = bcd_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed + randomized stimulus; expected output events
// are queued by the stimulus tasks and consumed by an independent monitor.
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int SDIV = 4;

  localparam int K_STATE = 0;
  localparam int K_CLR   = 1;
  localparam int K_INC   = 2;
  localparam int K_OVF   = 3;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        tick     = 1'b0;
  logic        btn_ss   = 1'b0;
  logic        btn_lr   = 1'b0;
  logic [15:0] count_in = 16'h0000;
  logic        inc;
  logic        clr;
  logic [1:0]  state;
  logic        ovf;
  logic [3:0]  disp_bcd;
  logic [3:0]  disp_an;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rcyc    = 0;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  // reference model of the visible control state
  logic [1:0]  m_state = S_IDLE;
  logic [15:0] m_lap   = 16'h0000;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_src   = 16'h0000;
  logic        mon_en  = 1'b0;
  logic        disp_en = 1'b0;

  logic [1:0]  prev_state = S_IDLE;
  logic        prev_ovf   = 1'b0;
  logic [3:0]  exp_an;
  logic [3:0]  exp_bcd;
  int          exp_idx;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .btn_ss   (btn_ss),
    .btn_lr   (btn_lr),
    .count_in (count_in),
    .inc      (inc),
    .clr      (clr),
    .state    (state),
    .ovf      (ovf),
    .disp_bcd (disp_bcd),
    .disp_an  (disp_an)
  );

  always #5 clock = ~clock;

  // edge counter, and edges since the last reset edge (drives scan index)
  always @(posedge clock) begin
    cyc  <= cyc + 1;
    rcyc <= reset ? 0 : rcyc + 1;
  end

  function automatic string kname(input int k);
    case (k)
      K_STATE: return "state";
      K_CLR:   return "clr";
      K_INC:   return "inc";
      default: return "ovf";
    endcase
  endfunction

  function automatic void push(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_ev(input int k, input int v);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event_%s: got %s=%0d at cycle %0d, required no event", kname(k), kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(k), kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // monitor: turn output activity into events and check the display scan
  always @(negedge clock) begin
    if (mon_en) begin
      if (state !== prev_state) check_ev(K_STATE, int'(state));
      if (clr === 1'b1)         check_ev(K_CLR, 1);
      if (inc === 1'b1)         check_ev(K_INC, 1);
      if (ovf !== prev_ovf)     check_ev(K_OVF, int'(ovf));
      prev_state = state;
      prev_ovf   = ovf;
      exp_idx = (rcyc / SDIV) % 4;
      exp_an  = 4'b0001 << exp_idx;
      n_tests++;
      if (disp_an !== exp_an) begin
        n_fail++;
        $display("FAIL disp_an: got %b at cycle %0d, required %b", disp_an, cyc, exp_an);
      end
      if (disp_en) begin
        exp_bcd = m_src[exp_idx*4 +: 4];
        n_tests++;
        if (disp_bcd !== exp_bcd) begin
          n_fail++;
          $display("FAIL disp_bcd: got %0d at cycle %0d, required %0d", disp_bcd, cyc, exp_bcd);
        end
      end
    end
  end

  // expected effect of one debounced press (or simultaneous pair)
  function automatic void model_press(input logic ss, input logic lr, input int ce);
    logic [1:0] nxt;
    logic       do_clr;
    nxt    = m_state;
    do_clr = 1'b0;
    if (ss) begin
      nxt = (m_state == S_RUN || m_state == S_LAP) ? S_PAUSE : S_RUN;
    end else if (lr) begin
      if (m_state == S_IDLE) do_clr = 1'b1;
      else if (m_state == S_RUN) begin
        nxt   = S_LAP;
        m_lap = count_in;
      end else if (m_state == S_LAP) nxt = S_RUN;
      else begin
        nxt    = S_IDLE;
        do_clr = 1'b1;
      end
    end
    if (nxt != m_state) push(K_STATE, int'(nxt), ce);
    if (do_clr) push(K_CLR, 1, ce);
    if (do_clr && m_ovf) begin
      push(K_OVF, 0, ce + 1);
      m_ovf = 1'b0;
    end
    m_state = nxt;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic disp_on();
    @(posedge clock);
    #2;
    m_src   = (m_state == S_LAP) ? m_lap : count_in;
    disp_en = 1'b1;
  endtask

  task automatic press(input logic ss, input logic lr, input int hold);
    int e;
    disp_en = 1'b0;
    @(posedge clock);
    #2;
    e = cyc;
    btn_ss = ss;
    btn_lr = lr;
    if (hold >= DEB) model_press(ss, lr, e + DEB + 3);
    $display("[TB] press ss=%0d lr=%0d hold=%0d at cycle %0d -> model state %0d", ss, lr, hold, e, m_state);
    repeat (hold) @(posedge clock);
    #2;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    idle(DEB + 8);
    disp_on();
  endtask

  task automatic tick_pulse();
    int t;
    @(posedge clock);
    #2;
    t    = cyc;
    tick = 1'b1;
    if (m_state == S_RUN || m_state == S_LAP) begin
      push(K_INC, 1, t + 1);
      if (count_in == 16'h5999 && !m_ovf) begin
        push(K_OVF, 1, t + 2);
        m_ovf = 1'b1;
      end
    end
    $display("[TB] tick at cycle %0d count_in=%h model state %0d", t, count_in, m_state);
    @(posedge clock);
    #2;
    tick = 1'b0;
    idle(2);
  endtask

  task automatic set_count(input logic [15:0] v);
    disp_en = 1'b0;
    @(posedge clock);
    #2;
    count_in = v;
    $display("[TB] count_in=%h at cycle %0d", v, cyc);
    disp_on();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_inc"}, int'(inc), 0);
    chk({tag, "_clr"}, int'(clr), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_disp_an"}, int'(disp_an), 1);
    chk({tag, "_disp_bcd"}, int'(disp_bcd), 0);
  endtask

  function automatic void model_reset(input int r);
    if (m_state != S_IDLE) push(K_STATE, int'(S_IDLE), r);
    if (m_ovf) push(K_OVF, 0, r);
    m_state = S_IDLE;
    m_ovf   = 1'b0;
    m_lap   = 16'h0000;
  endfunction

  task automatic pulse_reset(input int n);
    disp_en = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    model_reset(cyc + 1);
    $display("[TB] reset for %0d cycles at cycle %0d", n, cyc);
    repeat (n) @(posedge clock);
    #2;
    reset = 1'b0;
    check_reset_values("reset");
    disp_on();
  endtask

  // button held across a reset that lands while its debounce is in progress
  task automatic press_across_reset();
    int e;
    int r;
    disp_en = 1'b0;
    @(posedge clock);
    #2;
    e = cyc;
    r = e + DEB + 1;
    btn_ss = 1'b1;
    model_reset(r);
    model_press(1'b1, 1'b0, r + DEB + 3);
    $display("[TB] ss held across reset at cycle %0d", r);
    repeat (DEB) @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    check_reset_values("midreset");
    idle(DEB + 6);
    btn_ss = 1'b0;
    idle(DEB + 8);
    disp_on();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v[3:0]   = 4'($urandom_range(0, 9));
    v[7:4]   = 4'($urandom_range(0, 9));
    v[11:8]  = 4'($urandom_range(0, 9));
    v[15:12] = 4'($urandom_range(0, 5));
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    check_reset_values("por");
    mon_en = 1'b1;
    disp_on();

    // start from IDLE, ticks counted
    press(1'b1, 1'b0, 8);
    tick_pulse();
    tick_pulse();
    // short bounce: nothing happens
    press(1'b1, 1'b0, 2);
    // lap capture and lap display
    set_count(16'h0123);
    press(1'b0, 1'b1, 8);
    set_count(16'h0456);
    tick_pulse();
    idle(20);
    press(1'b0, 1'b1, 8);
    idle(20);
    // pause then reset to IDLE with a clear; ticks ignored
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    tick_pulse();
    press(1'b0, 1'b1, 6);
    // overflow and its clearing
    press(1'b1, 1'b0, 8);
    set_count(16'h5999);
    tick_pulse();
    tick_pulse();
    press(1'b1, 1'b0, 8);
    tick_pulse();
    press(1'b0, 1'b1, 8);
    // simultaneous presses from RUN, then reset
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b1, 8);
    pulse_reset(1);
    press_across_reset();
    press(1'b1, 1'b0, 8);
    set_count(16'h5999);
    tick_pulse();
    pulse_reset(2);

    for (int i = 0; i < 120; i++) begin
      op = int'($urandom_range(0, 99));
      if (op < 26)      press(1'b1, 1'b0, int'($urandom_range(DEB, DEB + 4)));
      else if (op < 52) press(1'b0, 1'b1, int'($urandom_range(DEB, DEB + 4)));
      else if (op < 60) press(1'b1, 1'b1, int'($urandom_range(DEB, DEB + 4)));
      else if (op < 66) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(1, DEB - 1)));
      else if (op < 86) tick_pulse();
      else if (op < 93) set_count(rand_bcd());
      else if (op < 98) set_count(16'h5999);
      else              pulse_reset(int'($urandom_range(1, 3)));
    end

    idle(10);
    mon_en = 1'b0;
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_%s: got no event, required %s=%0d at cycle %0d",
               kname(e.kind), kname(e.kind), e.val, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
